ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, duration of host clock-low inhibit.
REQ-003 SHALL have parameter START_TIMEOUT_US, default 15000, maximum wait for the first device clock falling edge.
REQ-004 SHALL have parameter FRAME_TIMEOUT_US, default 2000, maximum time from the first falling edge to the ACK.
REQ-005 SHALL have parameter MAX_RETRY, default 2, number of automatic resends after an error (0..7).
REQ-006 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on ps2_clk/ps2_data inputs (>=2).
REQ-007 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port ps2_clk, inout, 1, open-drain PS/2 clock: drives 0 or Z only.
REQ-010 SHALL have port ps2_data, inout, 1, open-drain PS/2 data: drives 0 or Z only.
REQ-011 SHALL have port wren, input, 1, single-cycle request to send d; accepted only when write=0.
REQ-012 SHALL have port d, input, 8, byte to send, captured on the accepting cycle.
REQ-013 SHALL have port write, output, 1, busy: high from the cycle after acceptance until completion.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on successful ACK.
REQ-015 SHALL have port err, output, 1, one-cycle pulse when retries are exhausted.
REQ-016 SHALL have port err_code, output, 2, cause of the last error, valid with err: 01 start timeout, 10 frame timeout, 11 no ACK.

Function
REQ-017 SHALL sample ps2_clk/ps2_data only through SYNC_STAGES flops; falling edge = sync previous 1, current 0.
REQ-018 SHALL implement states IDLE, INHIBIT, START, BITS, STOP, ACK, RELEASE, RETRY.
REQ-019 IDLE: when wren=1, SHALL capture frame {odd parity (~^d), d}, clear retry count, and enter INHIBIT; write=1 the next cycle.
REQ-020 SHALL ignore wren while write=1.
REQ-021 INHIBIT: SHALL drive ps2_clk=0 for exactly CLK_HZ*INHIBIT_US/1000000 cycles (integer division, minimum 1), then go to START.
REQ-022 START: SHALL drive ps2_data=0 and release ps2_clk in the same cycle, then go to BITS.
REQ-023 BITS: on each falling edge SHALL present the next frame bit on ps2_data (LSB first: d[0]..d[7], parity; 1 = Z); after the 9th bit is presented, the next falling edge SHALL go to STOP.
REQ-024 STOP: SHALL release ps2_data (stop bit = 1), then go to ACK.
REQ-025 ACK: SHALL go to RELEASE if sync data=0 at a falling edge, or to RETRY with code 11 if data=1 at that edge.
REQ-026 RELEASE: SHALL wait for sync clk=1 and data=1, then assert done for one cycle and return to IDLE with write=0 in that same cycle.
REQ-027 Start timeout: SHALL go to RETRY with code 01 if no falling edge occurs within START_TIMEOUT_US after leaving START.
REQ-028 Frame timeout: SHALL go to RETRY with code 10 if ACK is not detected within FRAME_TIMEOUT_US after the first falling edge; the timer SHALL cover BITS, STOP, and ACK.
REQ-029 RETRY: SHALL release both lines; if retries < MAX_RETRY, SHALL increment the count and re-enter INHIBIT with the same frame; otherwise SHALL pulse err, hold err_code, and return to IDLE.
REQ-030 Timers SHALL saturate, never wrap; counter widths SHALL be computed with $clog2 of the cycle counts.
REQ-031 done and err SHALL never be high in the same cycle.

Reset
REQ-032 On reset SHALL asynchronously enter IDLE: ps2_clk=Z, ps2_data=Z, write=0, done=0, err=0, err_code=00, counters=0, synchronizers=1.
REQ-033 Reset mid-frame SHALL abandon the frame immediately with no done/err pulse.

Structure
REQ-034 State encoding and err_code constants SHALL reside in shared package ps2_pkg, alongside the receive side.
REQ-035 SHALL instantiate one sub-module, ps2_sync (edge-detecting synchronizer for clk and data), reusable by the receiver.

Verification (CLK_HZ=24000000, INHIBIT_US=100)
REQ-036 SHALL check: wren with d=8'hED, device model clocks at 12.5 kHz and ACKs -> ps2_clk low 2400 cycles; bits on data are 1,0,1,1,0,1,1,1 then parity 1, then stop; one done pulse; write falls with done.
REQ-037 SHALL check: d=8'hFF with no ACK (data=1 at ack edge), MAX_RETRY=2 -> 3 full frames sent, then err=1 with err_code=11.
REQ-038 SHALL check: device never clocks -> err after 3×15 ms plus inhibits, err_code=01.
REQ-039 SHALL check: device stops clocking after 4 bits -> err_code=10 on the final attempt; lines released (Z) afterward.
REQ-040 SHALL check: second wren while busy and reset asserted in BITS -> second request ignored; after reset both lines Z, write=0, and no done/err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, error codes and
// microsecond-to-cycle conversion used by the host-side blocks.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_ACK,
        ST_RELEASE,
        ST_RETRY
    } tx_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    // Integer cycle count for a duration in microseconds, never below one.
    function automatic int cycles_of(input longint hz, input longint us);
        longint c;
        c = (hz * us) / longint'(1000000);
        if (c < longint'(1)) c = longint'(1);
        return int'(c);
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Synchronizer for the PS/2 clock and data lines with a clock falling-edge
// strobe; shared by the host transmitter and the receiver.
module ps2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line_clk,
    input  logic line_data,
    output logic sclk,
    output logic sdata,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Idle bus level is high, so the chains come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], line_clk};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], line_data};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign sclk      = clk_sr[SYNC_STAGES-1];
    assign sdata     = data_sr[SYNC_STAGES-1];
    assign sclk_fall = clk_prev & ~sclk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked-out
// data/parity/stop, ACK check, with start/frame timeouts and automatic resend.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ           = 24000000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000,
    parameter int MAX_RETRY        = 2,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic       wren,
    input  logic [7:0] d,
    output logic       write,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int INH_CYC   = cycles_of(longint'(CLK_HZ), longint'(INHIBIT_US));
    localparam int START_CYC = cycles_of(longint'(CLK_HZ), longint'(START_TIMEOUT_US));
    localparam int FRAME_CYC = cycles_of(longint'(CLK_HZ), longint'(FRAME_TIMEOUT_US));
    localparam int MAX_CYC   = (INH_CYC > START_CYC)
                             ? ((INH_CYC > FRAME_CYC) ? INH_CYC : FRAME_CYC)
                             : ((START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC);
    localparam int TW        = $clog2(MAX_CYC + 1);

    tx_state_t     state, state_nx;
    logic [8:0]    frame;
    logic [3:0]    bit_idx;
    logic [2:0]    retry_cnt;
    logic [TW-1:0] tmr, tmr_lim;
    logic          tmr_hit, tmr_clr;
    logic          seen, data_low, can_retry;
    logic [1:0]    code_q, code_nx;
    logic          clk_oe, data_oe;
    logic          sclk, sdata, sclk_fall;

    ps2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .line_clk  (ps2_clk),
        .line_data (ps2_data),
        .sclk      (sclk),
        .sdata     (sdata),
        .sclk_fall (sclk_fall)
    );

    assign can_retry = (retry_cnt < 3'(MAX_RETRY));

    // One timer serves all phases; the limit depends on where we are.
    always_comb begin
        tmr_lim = TW'(FRAME_CYC - 1);
        case (state)
            ST_INHIBIT: tmr_lim = TW'(INH_CYC - 1);
            ST_BITS:    tmr_lim = seen ? TW'(FRAME_CYC - 1) : TW'(START_CYC - 1);
            default:    tmr_lim = TW'(FRAME_CYC - 1);
        endcase
    end

    assign tmr_hit = (tmr >= tmr_lim);
    // Frame timer keeps running across BITS/STOP/ACK, so clear only at phase starts.
    assign tmr_clr = (state_nx == ST_INHIBIT && state != ST_INHIBIT) ||
                     (state == ST_START) ||
                     (state == ST_BITS && sclk_fall && !seen);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        code_nx  = ERR_FRAME;
        case (state)
            ST_IDLE:    if (wren) state_nx = ST_INHIBIT;
            ST_INHIBIT: if (tmr_hit) state_nx = ST_START;
            ST_START:   state_nx = ST_BITS;
            ST_BITS: begin
                if (sclk_fall) begin
                    if (bit_idx == 4'd9) state_nx = ST_STOP;
                end else if (tmr_hit) begin
                    state_nx = ST_RETRY;
                    code_nx  = seen ? ERR_FRAME : ERR_START;
                end
            end
            ST_STOP:    state_nx = tmr_hit ? ST_RETRY : ST_ACK;
            ST_ACK: begin
                if (sclk_fall) begin
                    if (sdata) begin
                        state_nx = ST_RETRY;
                        code_nx  = ERR_NOACK;
                    end else begin
                        state_nx = ST_RELEASE;
                    end
                end else if (tmr_hit) begin
                    state_nx = ST_RETRY;
                end
            end
            ST_RELEASE: if (sclk && sdata) state_nx = ST_IDLE;
            ST_RETRY:   state_nx = can_retry ? ST_INHIBIT : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        clk_oe  = 1'b0;
        data_oe = 1'b0;
        write   = (state != ST_IDLE);
        case (state)
            ST_INHIBIT: clk_oe  = 1'b1;
            ST_START:   data_oe = 1'b1;
            ST_BITS:    data_oe = data_low;
            default:    ;
        endcase
    end

    assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe ? 1'b0 : 1'bz;
    assign err_code = code_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame     <= '0;
            bit_idx   <= '0;
            retry_cnt <= '0;
            tmr       <= '0;
            seen      <= 1'b0;
            data_low  <= 1'b0;
            code_q    <= ERR_NONE;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (tmr_clr)          tmr <= '0;
            else if (tmr != '1)   tmr <= tmr + TW'(1);
            if (state_nx == ST_RETRY) code_q <= code_nx;
            case (state)
                ST_IDLE: if (wren) begin
                    frame     <= {~^d, d};
                    retry_cnt <= '0;
                end
                ST_START: begin
                    bit_idx  <= '0;
                    seen     <= 1'b0;
                    data_low <= 1'b1;
                end
                ST_BITS: if (sclk_fall) begin
                    seen <= 1'b1;
                    if (bit_idx != 4'd9) begin
                        data_low <= ~frame[bit_idx];
                        bit_idx  <= bit_idx + 4'd1;
                    end
                end
                ST_RELEASE: if (sclk && sdata) done <= 1'b1;
                ST_RETRY: begin
                    if (can_retry) retry_cnt <= retry_cnt + 3'd1;
                    else           err       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a full-speed instance for the 12.5 kHz ACK frame and a
// short-timeout instance for retry/timeout/reset cases, sharing one device model.
module tb_ps2_host_tx;

    typedef struct packed { logic is_err; logic [1:0] code; } exp_t;

    logic       clk, rst, wren, sel;
    logic [7:0] d;
    logic       dev_clk_low, dev_dat_low;
    wire        pclk_a, pdat_a, pclk_b, pdat_b;
    logic       write_a, done_a, err_a, write_b, done_b, err_b;
    logic [1:0] code_a, code_b;
    int         checks = 0;
    int         failures = 0;
    int         n_resp = 0;
    logic       prev_write = 1'b0;
    exp_t       exp_q[$];

    pullup pu_ca (pclk_a);
    pullup pu_da (pdat_a);
    pullup pu_cb (pclk_b);
    pullup pu_db (pdat_b);

    assign pclk_a = (!sel && dev_clk_low) ? 1'b0 : 1'bz;
    assign pdat_a = (!sel && dev_dat_low) ? 1'b0 : 1'bz;
    assign pclk_b = ( sel && dev_clk_low) ? 1'b0 : 1'bz;
    assign pdat_b = ( sel && dev_dat_low) ? 1'b0 : 1'bz;

    wire       cur_clk   = sel ? pclk_b  : pclk_a;
    wire       cur_data  = sel ? pdat_b  : pdat_a;
    wire       cur_done  = sel ? done_b  : done_a;
    wire       cur_err   = sel ? err_b   : err_a;
    wire       cur_write = sel ? write_b : write_a;
    wire [1:0] cur_code  = sel ? code_b  : code_a;

    ps2_host_tx u_dut_a (
        .clk(clk), .reset(rst), .ps2_clk(pclk_a), .ps2_data(pdat_a),
        .wren(wren && !sel), .d(d), .write(write_a), .done(done_a),
        .err(err_a), .err_code(code_a)
    );

    ps2_host_tx #(.INHIBIT_US(10), .START_TIMEOUT_US(20), .FRAME_TIMEOUT_US(50)) u_dut_b (
        .clk(clk), .reset(rst), .ps2_clk(pclk_b), .ps2_data(pdat_b),
        .wren(wren && sel), .d(d), .write(write_b), .done(done_b),
        .err(err_b), .err_code(code_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every done/err pulse consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (cur_done || cur_err)) begin
            checks++;
            n_resp++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp got done=%0b err=%0b code=%0d required none",
                         cur_done, cur_err, cur_code);
            end else begin
                e = exp_q.pop_front();
                if (cur_done == cur_err || cur_err != e.is_err ||
                    (e.is_err && cur_code != e.code) || cur_write || !prev_write) begin
                    failures++;
                    $display("FAIL resp got done=%0b err=%0b code=%0d write=%0b prev_write=%0b required err=%0b code=%0d write=0 prev_write=1",
                             cur_done, cur_err, cur_code, cur_write, prev_write, e.is_err, e.code);
                end
            end
        end
        prev_write = cur_write;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        wren = 1'b1;
        d    = v;
        @(negedge clk);
        wren = 1'b0;
    endtask

    // Device side: wait for inhibit then request-to-send, clock nfall edges,
    // sample data on each rising edge, optionally ACK on the 11th edge.
    task automatic dev_frame(input int half, input int nfall, input bit ack,
                             output logic [9:0] rx, output int inh);
        int n;
        rx = '0;
        inh = 0;
        n = 0;
        while (cur_clk !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        while (cur_clk === 1'b0 && n < 20000) begin inh++; @(negedge clk); n++; end
        while (!(cur_clk === 1'b1 && cur_data === 1'b0) && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            checks++;
            failures++;
            $display("FAIL dev_request_timeout waited=%0d required <20000", n);
            return;
        end
        tick(20);
        for (int i = 0; i < nfall; i++) begin
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                tick(5);
            end
            dev_clk_low = 1'b1;
            tick(half);
            dev_clk_low = 1'b0;
            if (i < 10) rx[i] = cur_data;
            tick(half);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_resp(input int target, input int bound, output int cyc);
        cyc = 0;
        while (n_resp < target && cyc < bound) begin @(negedge clk); cyc++; end
        checks++;
        if (n_resp < target) begin
            failures++;
            $display("FAIL resp_timeout got=%0d required=%0d", n_resp, target);
        end
    endtask

    initial begin
        logic [9:0] rx;
        int inh, cyc, lows;
        rst = 1'b1; wren = 1'b0; d = '0; sel = 1'b0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        tick(3);
        check("reset_a", {write_a, done_a, err_a, code_a, pclk_a, pdat_a}, 6'b000011);
        check("reset_b", {write_b, done_b, err_b, code_b, pclk_b, pdat_b}, 6'b000011);
        rst = 1'b0;
        tick(3);

        // 0xED at 12.5 kHz with ACK on the full-speed instance
        sel = 1'b0;
        exp_q.push_back(exp_t'{1'b0, 2'b00});
        send(8'hED);
        dev_frame(960, 11, 1'b1, rx, inh);
        check("inhibit_len", inh, 2400);
        check("frame_ed", rx, 10'h3ED);
        wait_resp(1, 5000, cyc);
        tick(50);
        check("single_done", n_resp, 1);

        // 0xFF never ACKed: three full frames then err 11
        sel = 1'b1;
        tick(5);
        exp_q.push_back(exp_t'{1'b1, 2'b11});
        send(8'hFF);
        for (int a = 0; a < 3; a++) begin
            dev_frame(40, 11, 1'b0, rx, inh);
            check("frame_ff", rx, 10'h3FF);
        end
        wait_resp(2, 2000, cyc);
        lows = 0;
        repeat (400) begin @(negedge clk); if (cur_clk === 1'b0) lows++; end
        check("no_4th_frame", lows, 0);

        // device never clocks: 3 x (inhibit + start timeout), err 01
        exp_q.push_back(exp_t'{1'b1, 2'b01});
        send(8'h3C);
        wait_resp(3, 4000, cyc);
        check("start_timeout_window", (cyc >= 2155 && cyc <= 2180), 1);

        // device stops after 4 bits: err 10, lines released afterwards
        exp_q.push_back(exp_t'{1'b1, 2'b10});
        send(8'hA5);
        for (int a = 0; a < 3; a++) begin
            dev_frame(40, 4, 1'b0, rx, inh);
            check("frame_a5_first4", rx[3:0], 4'h5);
        end
        wait_resp(4, 3000, cyc);
        tick(2);
        check("lines_released", {cur_clk, cur_data}, 2'b11);

        // second request while busy is dropped; reset in BITS abandons frame
        send(8'h5A);
        tick(3);
        send(8'hA5);
        dev_frame(40, 3, 1'b0, rx, inh);
        check("busy_ignored_bits", rx[2:0], 3'b010);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_frame", {write_b, cur_clk, cur_data}, 3'b011);
        tick(3);
        rst = 1'b0;
        tick(300);
        check("no_resp_after_reset", n_resp, 4);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
